// File: rtl/alu_operand_stage_if.sv
// Interface bundling the decode-side offer, forwarding taps and ALU-side
// handshake of the ID/EX operand stage.
interface alu_operand_stage_if #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [REG_AW-1:0]   in_rs1_addr;
    logic [REG_AW-1:0]   in_rs2_addr;
    logic [XLEN-1:0]     in_rs1_data;
    logic [XLEN-1:0]     in_rs2_data;
    logic [XLEN-1:0]     in_imm;
    logic                in_use_imm;
    logic [3:0]          in_alu_op;
    logic [REG_AW-1:0]   in_rd_addr;
    logic                in_reg_write;

    logic                exmem_reg_write;
    logic [REG_AW-1:0]   exmem_rd;
    logic [XLEN-1:0]     exmem_result;
    logic                memwb_reg_write;
    logic [REG_AW-1:0]   memwb_rd;
    logic [XLEN-1:0]     memwb_result;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [3:0]          alu_op;
    logic [REG_AW-1:0]   out_rd_addr;
    logic                out_reg_write;
    logic [STALL_CW-1:0] stall_cnt;

    // The stage itself.
    modport slave (
        input  flush, in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_op, in_rd_addr, in_reg_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd_addr,
               out_reg_write, stall_cnt
    );

    // The surrounding pipeline (decode, later stages, ALU).
    modport master (
        output flush, in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_op, in_rd_addr, in_reg_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd_addr,
               out_reg_write, stall_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU: holds decoded operands, forwards
// from EX/MEM and MEM/WB, selects operand B and counts back-pressure cycles.
module alu_operand_stage #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
) (
    input logic                clk,
    input logic                rst_n,
    alu_operand_stage_if.slave bus
);

    localparam logic [3:0]          OP_SHIFT_A = 4'b1000;
    localparam logic [3:0]          OP_SHIFT_B = 4'b1001;
    localparam logic [3:0]          OP_SHIFT_C = 4'b1010;
    localparam logic [STALL_CW-1:0] STALL_ONE  = {{(STALL_CW-1){1'b0}}, 1'b1};
    localparam logic [STALL_CW-1:0] STALL_MAX  = {STALL_CW{1'b1}};
    localparam logic [REG_AW-1:0]   REG_ZERO   = '0;

    logic                out_valid_q;
    logic [REG_AW-1:0]   rs1_addr_q;
    logic [REG_AW-1:0]   rs2_addr_q;
    logic [XLEN-1:0]     rs1_data_q;
    logic [XLEN-1:0]     rs2_data_q;
    logic [XLEN-1:0]     imm_q;
    logic                use_imm_q;
    logic [3:0]          alu_op_q;
    logic [REG_AW-1:0]   rd_q;
    logic                reg_write_q;
    logic [STALL_CW-1:0] stall_q;

    logic                in_ready;
    logic                capture;
    logic                stalled;
    logic [XLEN-1:0]     fwd_rs1;
    logic [XLEN-1:0]     fwd_rs2;
    logic                is_shift;
    logic [XLEN-1:0]     imm_sel;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign capture  = bus.in_valid && in_ready && !bus.flush;
    assign stalled  = out_valid_q && !bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (capture) begin
            rs1_addr_q  <= bus.in_rs1_addr;
            rs2_addr_q  <= bus.in_rs2_addr;
            rs1_data_q  <= bus.in_rs1_data;
            rs2_data_q  <= bus.in_rs2_data;
            imm_q       <= bus.in_imm;
            use_imm_q   <= bus.in_use_imm;
            alu_op_q    <= bus.in_alu_op;
            rd_q        <= bus.in_rd_addr;
            reg_write_q <= bus.in_reg_write;
        end
    end

    // Saturating; flush does not clear it, only reset does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + STALL_ONE;
        end
    end

    // Forwarding compares the held source indices against the live later-stage
    // ports, so results arriving during a stall still reach the ALU.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == rs1_addr_q) && (rs1_addr_q != REG_ZERO)) begin
            fwd_rs1 = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd == rs1_addr_q) && (rs1_addr_q != REG_ZERO)) begin
            fwd_rs1 = bus.memwb_result;
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == rs2_addr_q) && (rs2_addr_q != REG_ZERO)) begin
            fwd_rs2 = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd == rs2_addr_q) && (rs2_addr_q != REG_ZERO)) begin
            fwd_rs2 = bus.memwb_result;
        end
    end

    // Shift immediates only carry a 5-bit shift amount.
    assign is_shift = (alu_op_q == OP_SHIFT_A) || (alu_op_q == OP_SHIFT_B) || (alu_op_q == OP_SHIFT_C);
    assign imm_sel  = is_shift ? {{(XLEN-5){1'b0}}, imm_q[4:0]} : imm_q;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.alu_a         = fwd_rs1;
    assign bus.alu_b         = use_imm_q ? imm_sel : fwd_rs2;
    assign bus.alu_op        = alu_op_q;
    assign bus.out_rd_addr   = rd_q;
    assign bus.out_reg_write = reg_write_q && out_valid_q;
    assign bus.stall_cnt     = stall_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage; a second instance with a
// 3-bit stall counter mirrors the stimulus to exercise saturation.
module tb_alu_operand_stage;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    alu_operand_stage_if #(.XLEN(32), .REG_AW(5), .STALL_CW(16)) bus0 ();
    alu_operand_stage_if #(.XLEN(32), .REG_AW(5), .STALL_CW(3))  bus1 ();

    alu_operand_stage #(.XLEN(32), .REG_AW(5), .STALL_CW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    alu_operand_stage #(.XLEN(32), .REG_AW(5), .STALL_CW(3)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    assign bus1.flush           = bus0.flush;
    assign bus1.in_valid        = bus0.in_valid;
    assign bus1.in_rs1_addr     = bus0.in_rs1_addr;
    assign bus1.in_rs2_addr     = bus0.in_rs2_addr;
    assign bus1.in_rs1_data     = bus0.in_rs1_data;
    assign bus1.in_rs2_data     = bus0.in_rs2_data;
    assign bus1.in_imm          = bus0.in_imm;
    assign bus1.in_use_imm      = bus0.in_use_imm;
    assign bus1.in_alu_op       = bus0.in_alu_op;
    assign bus1.in_rd_addr      = bus0.in_rd_addr;
    assign bus1.in_reg_write    = bus0.in_reg_write;
    assign bus1.exmem_reg_write = bus0.exmem_reg_write;
    assign bus1.exmem_rd        = bus0.exmem_rd;
    assign bus1.exmem_result    = bus0.exmem_result;
    assign bus1.memwb_reg_write = bus0.memwb_reg_write;
    assign bus1.memwb_rd        = bus0.memwb_rd;
    assign bus1.memwb_result    = bus0.memwb_result;
    assign bus1.out_ready       = bus0.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [4:0] rs2a, input logic [31:0] rs2d,
                         input logic [31:0] imm, input logic use_imm,
                         input logic [3:0] op, input logic [4:0] rd, input logic rw);
        bus0.in_rs1_addr  = rs1a;
        bus0.in_rs1_data  = rs1d;
        bus0.in_rs2_addr  = rs2a;
        bus0.in_rs2_data  = rs2d;
        bus0.in_imm       = imm;
        bus0.in_use_imm   = use_imm;
        bus0.in_alu_op    = op;
        bus0.in_rd_addr   = rd;
        bus0.in_reg_write = rw;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        bus0.flush           = 1'b0;
        bus0.in_valid        = 1'b0;
        bus0.out_ready       = 1'b0;
        bus0.exmem_reg_write = 1'b0;
        bus0.exmem_rd        = 5'd0;
        bus0.exmem_result    = 32'h0;
        bus0.memwb_reg_write = 1'b0;
        bus0.memwb_rd        = 5'd0;
        bus0.memwb_result    = 32'h0;
        drive(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0);

        // Reset state
        #1;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'h0);
        chk("rst_alu_a", bus0.alu_a, 32'h0);
        chk("rst_alu_b", bus0.alu_b, 32'h0);
        chk("rst_alu_op", 32'(bus0.alu_op), 32'h0);
        chk("rst_reg_write", 32'(bus0.out_reg_write), 32'h0);
        chk("rst_stall_cnt", 32'(bus0.stall_cnt), 32'h0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'h1);
        tick();
        tick();
        rst_n = 1'b1;

        // Pass-through with immediate
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        drive(5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 1'b1, 4'h0, 5'd4, 1'b1);
        tick();
        bus0.in_valid = 1'b0;
        chk("pt_out_valid", 32'(bus0.out_valid), 32'h1);
        chk("pt_alu_a", bus0.alu_a, 32'd5);
        chk("pt_alu_b", bus0.alu_b, 32'd7);
        chk("pt_alu_op", 32'(bus0.alu_op), 32'h0);
        chk("pt_rd", 32'(bus0.out_rd_addr), 32'd4);
        chk("pt_reg_write", 32'(bus0.out_reg_write), 32'h1);

        // Drain
        tick();
        chk("drain_out_valid", 32'(bus0.out_valid), 32'h0);
        chk("drain_reg_write", 32'(bus0.out_reg_write), 32'h0);

        // Register operand B, then forwarding while held
        bus0.in_valid = 1'b1;
        drive(5'd3, 32'h11, 5'd6, 32'h22, 32'h0, 1'b0, 4'h1, 5'd7, 1'b1);
        tick();
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        chk("reg_alu_a", bus0.alu_a, 32'h11);
        chk("reg_alu_b", bus0.alu_b, 32'h22);
        chk("reg_alu_op", 32'(bus0.alu_op), 32'h1);
        bus0.exmem_reg_write = 1'b1;
        bus0.exmem_rd        = 5'd3;
        bus0.exmem_result    = 32'hAA;
        bus0.memwb_reg_write = 1'b1;
        bus0.memwb_rd        = 5'd3;
        bus0.memwb_result    = 32'hBB;
        #1;
        chk("fwd_exmem_prio", bus0.alu_a, 32'hAA);
        chk("fwd_rs2_nohit", bus0.alu_b, 32'h22);
        bus0.exmem_reg_write = 1'b0;
        #1;
        chk("fwd_memwb", bus0.alu_a, 32'hBB);
        bus0.memwb_rd = 5'd6;
        #1;
        chk("fwd_rs2_memwb", bus0.alu_b, 32'hBB);
        chk("fwd_rs1_cleared", bus0.alu_a, 32'h11);
        bus0.memwb_reg_write = 1'b0;

        // Stall: 4 cycles back-pressure with a pending offer
        bus0.in_valid = 1'b1;
        drive(5'd8, 32'h99, 5'd9, 32'h98, 32'h0, 1'b0, 4'h3, 5'd9, 1'b1);
        #1;
        chk("stall_in_ready", 32'(bus0.in_ready), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("stall_cnt_4", 32'(bus0.stall_cnt), 32'd4);
        chk("stall_held_a", bus0.alu_a, 32'h11);
        chk("stall_held_op", 32'(bus0.alu_op), 32'h1);
        chk("stall_held_rd", 32'(bus0.out_rd_addr), 32'd7);
        chk("stall_out_valid", 32'(bus0.out_valid), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        chk("stall_cnt_8", 32'(bus0.stall_cnt), 32'd8);
        chk("stall_sat", 32'(bus1.stall_cnt), 32'd7);

        // Release with x0 as rs1
        bus0.out_ready = 1'b1;
        drive(5'd0, 32'h55, 5'd5, 32'h66, 32'h0, 1'b0, 4'h2, 5'd2, 1'b1);
        #1;
        chk("release_in_ready", 32'(bus0.in_ready), 32'h1);
        tick();
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        chk("release_stall_cnt", 32'(bus0.stall_cnt), 32'd8);
        bus0.exmem_reg_write = 1'b1;
        bus0.exmem_rd        = 5'd0;
        bus0.exmem_result    = 32'hAA;
        bus0.memwb_reg_write = 1'b1;
        bus0.memwb_rd        = 5'd0;
        bus0.memwb_result    = 32'hBB;
        #1;
        chk("x0_no_fwd", bus0.alu_a, 32'h55);
        chk("x0_rs2_held", bus0.alu_b, 32'h66);
        bus0.exmem_rd = 5'd5;
        #1;
        chk("fwd_rs2_exmem", bus0.alu_b, 32'hAA);
        bus0.exmem_reg_write = 1'b0;
        bus0.memwb_reg_write = 1'b0;

        // Flush with a held instruction and a new offer
        bus0.flush    = 1'b1;
        bus0.in_valid = 1'b1;
        drive(5'd1, 32'h77, 5'd2, 32'h78, 32'h0, 1'b0, 4'h4, 5'd12, 1'b1);
        tick();
        bus0.flush    = 1'b0;
        bus0.in_valid = 1'b0;
        chk("flush_out_valid", 32'(bus0.out_valid), 32'h0);
        chk("flush_reg_write", 32'(bus0.out_reg_write), 32'h0);
        chk("flush_stall_cnt", 32'(bus0.stall_cnt), 32'd9);
        tick();
        chk("flush_dropped_valid", 32'(bus0.out_valid), 32'h0);
        chk("flush_dropped_a", bus0.alu_a, 32'h55);
        chk("flush_dropped_rd", 32'(bus0.out_rd_addr), 32'd2);

        // Shift immediate vs plain immediate, back to back
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        drive(5'd1, 32'h1, 5'd2, 32'h2, 32'hFFFF_FFE3, 1'b1, 4'hA, 5'd3, 1'b1);
        tick();
        chk("shift_alu_b", bus0.alu_b, 32'h0000_0003);
        chk("shift_alu_op", 32'(bus0.alu_op), 32'hA);
        drive(5'd1, 32'h1, 5'd2, 32'h2, 32'hFFFF_FFE3, 1'b1, 4'h0, 5'd3, 1'b1);
        tick();
        bus0.in_valid = 1'b0;
        chk("add_imm_alu_b", bus0.alu_b, 32'hFFFF_FFE3);
        chk("b2b_out_valid", 32'(bus0.out_valid), 32'h1);

        // Asynchronous reset mid-stream, observed before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus0.out_valid), 32'h0);
        chk("async_rst_alu_a", bus0.alu_a, 32'h0);
        chk("async_rst_alu_b", bus0.alu_b, 32'h0);
        chk("async_rst_stall", 32'(bus0.stall_cnt), 32'h0);
        chk("async_rst_sat_stall", 32'(bus1.stall_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
